// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader
//   Input stage in front of the fft accelerator. Collects one frame of SIZE
//   samples in natural order from an AXI-Stream source, then replays it in
//   bit-reversed index order on an AXI-Stream master. m00_axis_tlast marks
//   the final word. A one-cycle start pulse follows the final output handshake.
//   Short frames are zero-padded and long frames are truncated.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   FILL    | accepting input beats, writing mem[wr_cnt] in natural order
//   PAD     | short frame: writing zeros until index SIZE-1 is filled
//   DISCARD | long frame: accepting and dropping beats until tlast
//   DRAIN   | presenting mem[bitrev(rd_cnt)] on the master stream
//   START   | one-cycle start pulse, counters cleared
//
// Ports
//   s00_axi_aclk, s00_axi_areset     : clock, async active-high reset
//   s00_axis_t{ready,data,last,valid}: input stream (slave)
//   m00_axis_t{valid,data,strb,last,ready}: reordered output stream (master)
//   start        : one-cycle pulse after the frame has been delivered
//   frame_status : bit0 = last frame padded, bit1 = last frame truncated
module fft_bitrev_loader #(
  parameter int SIZE       = 8,
  parameter int LOG2_SIZE  = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  output logic                    s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                    s00_axis_tlast,
  input  logic                    s00_axis_tvalid,
  output logic                    m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  output logic                    start,
  output logic [1:0]              frame_status
);

  typedef enum logic [2:0] {
    S_FILL    = 3'd0,
    S_PAD     = 3'd1,
    S_DISCARD = 3'd2,
    S_DRAIN   = 3'd3,
    S_START   = 3'd4
  } state_t;

  localparam logic [LOG2_SIZE-1:0] LAST_IDX = LOG2_SIZE'(SIZE - 1);
  localparam logic [LOG2_SIZE-1:0] CNT_ONE  = LOG2_SIZE'(1);

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   mem [SIZE];
  logic [LOG2_SIZE-1:0]    wr_cnt, wr_cnt_nxt;
  logic [LOG2_SIZE-1:0]    rd_cnt, rd_cnt_nxt;
  logic                    s_hs, m_hs;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    status_we;
  logic [1:0]              status_nxt;

  function automatic logic [LOG2_SIZE-1:0] bitrev(input logic [LOG2_SIZE-1:0] a);
    logic [LOG2_SIZE-1:0] r;
    for (int i = 0; i < LOG2_SIZE; i++) r[i] = a[LOG2_SIZE-1-i];
    return r;
  endfunction

  assign s_hs           = s00_axis_tvalid & s00_axis_tready;
  assign m_hs           = m00_axis_tvalid & m00_axis_tready;
  assign m00_axis_tstrb = '1;
  // rd_cnt only moves on a handshake, so data is stable while stalled.
  assign m00_axis_tdata = mem[bitrev(rd_cnt)];

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) state <= S_FILL;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    mem_we     = 1'b0;
    mem_wdata  = s00_axis_tdata;
    status_we  = 1'b0;
    status_nxt = frame_status;
    case (state)
      S_FILL: begin
        if (s_hs) begin
          mem_we = 1'b1;
          if (s00_axis_tlast) begin
            status_we = 1'b1;
            if (wr_cnt == LAST_IDX) begin
              status_nxt = 2'b00;
              state_nxt  = S_DRAIN;
            end else begin
              status_nxt = 2'b01;
              wr_cnt_nxt = wr_cnt + CNT_ONE;
              state_nxt  = S_PAD;
            end
          end else if (wr_cnt == LAST_IDX) begin
            status_we  = 1'b1;
            status_nxt = 2'b10;
            state_nxt  = S_DISCARD;
          end else begin
            wr_cnt_nxt = wr_cnt + CNT_ONE;
          end
        end
      end
      S_PAD: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        if (wr_cnt == LAST_IDX) state_nxt = S_DRAIN;
        else                    wr_cnt_nxt = wr_cnt + CNT_ONE;
      end
      S_DISCARD: begin
        if (s_hs && s00_axis_tlast) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (m_hs) begin
          if (rd_cnt == LAST_IDX) state_nxt = S_START;
          else                    rd_cnt_nxt = rd_cnt + CNT_ONE;
        end
      end
      S_START: begin
        wr_cnt_nxt = '0;
        rd_cnt_nxt = '0;
        state_nxt  = S_FILL;
      end
      default: begin
        wr_cnt_nxt = '0;
        rd_cnt_nxt = '0;
        state_nxt  = S_FILL;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register rather than trailing it by a cycle.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      s00_axis_tready <= 1'b1;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      start           <= 1'b0;
      frame_status    <= 2'b00;
    end else begin
      wr_cnt          <= wr_cnt_nxt;
      rd_cnt          <= rd_cnt_nxt;
      s00_axis_tready <= (state_nxt == S_FILL) || (state_nxt == S_DISCARD);
      m00_axis_tvalid <= (state_nxt == S_DRAIN);
      m00_axis_tlast  <= (state_nxt == S_DRAIN) && (rd_cnt_nxt == LAST_IDX);
      start           <= (state_nxt == S_START);
      if (status_we) frame_status <= status_nxt;
    end
  end

  // Storage has no reset; contents are rewritten every frame.
  always_ff @(posedge s00_axi_aclk) begin
    if (mem_we) mem[wr_cnt] <= mem_wdata;
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
module tb_fft_bitrev_loader;
  localparam int SIZE = 8;
  localparam int LOG2_SIZE = 3;
  localparam int DW = 32;

  logic          s00_axi_aclk = 1'b0;
  logic          s00_axi_areset;
  logic          s00_axis_tready;
  logic [DW-1:0] s00_axis_tdata;
  logic          s00_axis_tlast;
  logic          s00_axis_tvalid;
  logic          m00_axis_tvalid;
  logic [DW-1:0] m00_axis_tdata;
  logic [DW/8-1:0] m00_axis_tstrb;
  logic          m00_axis_tlast;
  logic          m00_axis_tready;
  logic          start;
  logic [1:0]    frame_status;

  fft_bitrev_loader #(.SIZE(SIZE), .LOG2_SIZE(LOG2_SIZE), .DATA_WIDTH(DW)) dut (
    .s00_axi_aclk    (s00_axi_aclk),
    .s00_axi_areset  (s00_axi_areset),
    .s00_axis_tready (s00_axis_tready),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tvalid (s00_axis_tvalid),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tready (m00_axis_tready),
    .start           (start),
    .frame_status    (frame_status)
  );

  always #5 s00_axi_aclk = ~s00_axi_aclk;

  int cyc = 0;
  always @(posedge s00_axi_aclk) cyc++;

  int checks = 0;
  int failures = 0;
  int last_start_cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mirror the index bits arithmetically: peel LSBs off k, push them into r.
  function automatic int rev_idx(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < LOG2_SIZE; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // tr_mode: 0 = downstream always ready, 1 = 1,0,0,1 pattern, 2 = random.
  // abort_at > 0: reset the DUT after that many output handshakes.
  task automatic run_frame(input int len, input int tr_mode, input int gap_pct,
                           input bit seq, input logic [31:0] base, input int abort_at);
    logic [31:0] in_q[$];
    logic [31:0] nat [SIZE];
    logic [31:0] exp_out [SIZE];
    logic [1:0]  exp_st;
    logic [31:0] prev_data;
    logic        prev_last;
    bit          hold, done, prev_stall;
    int          idx, ocnt, starts, pads, hs_cyc, budget;
    hold = 0; done = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
    idx = 0; ocnt = 0; starts = 0; pads = 0; hs_cyc = -10; budget = 0;

    for (int i = 0; i < len; i++) in_q.push_back(seq ? base + 32'(i) : $urandom);
    for (int i = 0; i < SIZE; i++) nat[i] = (i < len) ? in_q[i] : 32'd0;
    for (int k = 0; k < SIZE; k++) exp_out[k] = nat[rev_idx(k)];
    exp_st = (len == SIZE) ? 2'b00 : (len < SIZE) ? 2'b01 : 2'b10;

    while (!done && budget < 1000) begin
      @(negedge s00_axi_aclk);
      budget++;
      if (!hold) s00_axis_tvalid = (idx < len) && ($urandom_range(99) >= gap_pct);
      s00_axis_tdata = (idx < len) ? in_q[idx] : 32'd0;
      s00_axis_tlast = (idx == len - 1);
      case (tr_mode)
        0:       m00_axis_tready = 1'b1;
        1:       m00_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m00_axis_tready = ($urandom_range(99) >= 40);
      endcase
      #1;
      if (prev_stall) begin
        check_eq("stall_valid", 32'(m00_axis_tvalid), 32'd1);
        check_eq("stall_data", m00_axis_tdata, prev_data);
        check_eq("stall_last", 32'(m00_axis_tlast), 32'(prev_last));
      end
      if (s00_axis_tvalid && s00_axis_tready) idx++;
      hold = s00_axis_tvalid && !s00_axis_tready;
      if (!s00_axis_tready && !m00_axis_tvalid && !start) pads++;
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (ocnt < SIZE) begin
          check_eq("out_data", m00_axis_tdata, exp_out[ocnt]);
          check_eq("out_last", 32'(m00_axis_tlast), 32'(ocnt == SIZE - 1));
        end else begin
          check_eq("extra_handshake", 32'(ocnt), 32'(SIZE - 1));
        end
        ocnt++;
        hs_cyc = cyc;
        if (abort_at > 0 && ocnt == abort_at) done = 1;
      end
      prev_stall = m00_axis_tvalid && !m00_axis_tready;
      prev_data  = m00_axis_tdata;
      prev_last  = m00_axis_tlast;
      if (start) begin
        starts++;
        check_eq("start_latency", 32'(cyc), 32'(hs_cyc + 1));
        if (last_start_cyc >= 0)
          check_eq("start_gap", 32'(cyc - last_start_cyc >= SIZE), 32'd1);
        last_start_cyc = cyc;
        done = 1;
      end
    end
    if (!done) check_eq("timeout", 32'd0, 32'd1);

    if (abort_at > 0) begin
      @(negedge s00_axi_aclk);
      s00_axi_areset  = 1'b1;
      s00_axis_tvalid = 1'b0;
      #1;
      check_eq("abort_tvalid", 32'(m00_axis_tvalid), 32'd0);
      check_eq("abort_tready", 32'(s00_axis_tready), 32'd1);
      check_eq("abort_status", 32'(frame_status), 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge s00_axi_aclk);
        #1;
        check_eq("abort_no_start", 32'(start), 32'd0);
      end
      s00_axi_areset = 1'b0;
      last_start_cyc = -1;
    end else begin
      check_eq("out_count", 32'(ocnt), 32'(SIZE));
      check_eq("start_count", 32'(starts), 32'd1);
      check_eq("in_count", 32'(idx), 32'(len));
      check_eq("pad_cycles", 32'(pads), 32'((len < SIZE) ? SIZE - len : 0));
      check_eq("frame_status", 32'(frame_status), 32'(exp_st));
    end
  endtask

  initial begin
    s00_axi_areset  = 1'b1;
    s00_axis_tvalid = 1'b0;
    s00_axis_tdata  = '0;
    s00_axis_tlast  = 1'b0;
    m00_axis_tready = 1'b0;
    repeat (3) @(negedge s00_axi_aclk);
    #1;
    check_eq("rst_tready", 32'(s00_axis_tready), 32'd1);
    check_eq("rst_tvalid", 32'(m00_axis_tvalid), 32'd0);
    check_eq("rst_tlast", 32'(m00_axis_tlast), 32'd0);
    check_eq("rst_start", 32'(start), 32'd0);
    check_eq("rst_status", 32'(frame_status), 32'd0);
    check_eq("tstrb", 32'(m00_axis_tstrb), 32'hF);
    s00_axi_areset = 1'b0;

    run_frame(8, 0, 0, 1, 32'd0, 0);     // natural 0..7
    run_frame(8, 1, 0, 1, 32'd0, 0);     // backpressure pattern
    run_frame(5, 0, 0, 1, 32'd10, 0);    // short: 10..14
    run_frame(10, 0, 0, 1, 32'd20, 0);   // long: 20..29
    run_frame(8, 0, 0, 1, 32'd100, 3);   // reset mid-drain
    run_frame(8, 2, 20, 0, 32'd0, 0);    // recovery frame
    run_frame(8, 0, 0, 0, 32'd0, 0);     // back-to-back pair
    run_frame(8, 2, 0, 0, 32'd0, 0);
    repeat (20) run_frame(int'($urandom_range(1, 12)), 2, 30, 0, 32'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
